decode_queue: RTL and testbench
===============================

# decode_queue

Elastic FIFO between the decode pipeline register and the rename/dispatch stage. Captures decoded bundles (pc, instruction, control signals, ALU select, immediate) under a valid/ready handshake and presents them in program order. Absorbs downstream stalls without stopping decode. Supports a single-cycle flush for branch mispredicts.

## Interface
- ADDR_WIDTH, 12, PC width
- INSTR_WIDTH, 32, raw instruction width
- C_SIG_WIDTH, 7, control-signal bundle width
- ALU_SIG_WIDTH, 3, ALU operation select width
- DEPTH, 4, entry count; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all entries
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  queue can accept a bundle
- pc_in  in  ADDR_WIDTH  bundle PC
- instr_in  in  INSTR_WIDTH  bundle instruction
- c_sig_in  in  C_SIG_WIDTH  bundle control signals
- alu_sig_in  in  ALU_SIG_WIDTH  bundle ALU select
- imm_in  in  32  bundle immediate
- out_valid  out  1  head bundle valid
- out_ready  in  1  downstream accepts head
- pc_out, instr_out, c_sig_out, alu_sig_out, imm_out  out  same widths as inputs  head bundle fields
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer, write pointer, read pointer, occupancy counter; pointers $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); independent of out_ready (no combinational ready path through the queue).
- out_valid = (count != 0).
- Output fields driven from entry at read pointer; forced to all zeros when out_valid = 0.
- Push: write bundle at write pointer, increment write pointer.
- Pop: increment read pointer.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (count = DEPTH): in_ready = 0; in_valid ignored; pop still allowed.
- Empty (count = 0): out_valid = 0; out_ready ignored; no pass-through of input to output.
- Flush: pointers and count cleared to 0 at the edge; any push or pop in the same cycle is discarded; entry contents need not be cleared.
- Flush has priority over push/pop; rst_n has priority over everything.
- Holding in_valid with data changing while in_ready = 0 is legal; only the value present on the accepting edge is stored.

## Timing
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, out_valid = 0, in_ready = 1, all output fields = 0; held while rst_n low. Reset deassertion mid-stream discards all entries.
- Latency: bundle pushed at edge N is visible on outputs with out_valid = 1 in cycle after edge N (one cycle, empty queue).
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- in_ready, out_valid, count are pure functions of registered state (no combinational dependence on inputs).
- After flush edge: out_valid = 0, in_ready = 1 in the following cycle.

## Test plan
- Reset then idle: rst_n low 2 cycles, release -> count = 0, out_valid = 0, in_ready = 1, pc_out = 0, imm_out = 0.
- Fill: push pc 0x004, 0x008, 0x00C, 0x010 with out_ready = 0 -> count = 4, in_ready = 0, pc_out = 0x004; fifth push of 0x014 held 3 cycles is not stored.
- Drain in order: from full, out_ready = 1 for 4 cycles -> pc_out sequence 0x004, 0x008, 0x00C, 0x010, then out_valid = 0, count = 0.
- Simultaneous push/pop at count = 2 for 6 cycles -> count stays 2, pointers wrap past entry 3, PCs emerge in exact push order with imm/c_sig/alu_sig matching.
- Full with out_ready = 1 and in_valid = 1 -> pop only, count 4 -> 3, incoming bundle accepted next cycle.
- Flush with simultaneous push at count = 3 -> next cycle count = 0, out_valid = 0; pushed bundle absent. Assert rst_n low mid-drain -> outputs zero immediately, without clock edge.

Source files
------------

// File: rtl/decode_queue.sv
// Elastic FIFO between decode and rename/dispatch: circular buffer of decoded
// bundles with valid/ready on both sides and a single-cycle flush.
module decode_queue #(
    parameter int ADDR_WIDTH    = 12,
    parameter int INSTR_WIDTH   = 32,
    parameter int C_SIG_WIDTH   = 7,
    parameter int ALU_SIG_WIDTH = 3,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      pc_in,
    input  logic [INSTR_WIDTH-1:0]     instr_in,
    input  logic [C_SIG_WIDTH-1:0]     c_sig_in,
    input  logic [ALU_SIG_WIDTH-1:0]   alu_sig_in,
    input  logic [31:0]                imm_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      pc_out,
    output logic [INSTR_WIDTH-1:0]     instr_out,
    output logic [C_SIG_WIDTH-1:0]     c_sig_out,
    output logic [ALU_SIG_WIDTH-1:0]   alu_sig_out,
    output logic [31:0]                imm_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0]    r_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0]   r_instr [DEPTH];
    logic [C_SIG_WIDTH-1:0]   r_c_sig [DEPTH];
    logic [ALU_SIG_WIDTH-1:0] r_alu   [DEPTH];
    logic [31:0]              r_imm   [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Ready/valid derive only from the registered count, never from the other side.
    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]    <= pc_in;
            r_instr[r_wr_ptr] <= instr_in;
            r_c_sig[r_wr_ptr] <= c_sig_in;
            r_alu[r_wr_ptr]   <= alu_sig_in;
            r_imm[r_wr_ptr]   <= imm_in;
        end
    end

    always_comb begin
        pc_out      = '0;
        instr_out   = '0;
        c_sig_out   = '0;
        alu_sig_out = '0;
        imm_out     = '0;
        if (out_valid) begin
            pc_out      = r_pc[r_rd_ptr];
            instr_out   = r_instr[r_rd_ptr];
            c_sig_out   = r_c_sig[r_rd_ptr];
            alu_sig_out = r_alu[r_rd_ptr];
            imm_out     = r_imm[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (default parameters).
module tb_decode_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] pc_in;
    logic [31:0] instr_in;
    logic [6:0]  c_sig_in;
    logic [2:0]  alu_sig_in;
    logic [31:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] pc_out;
    logic [31:0] instr_out;
    logic [6:0]  c_sig_out;
    logic [2:0]  alu_sig_out;
    logic [31:0] imm_out;
    logic [2:0]  count;

    int unsigned n_pass;
    int unsigned n_total;

    decode_queue #(
        .ADDR_WIDTH(12),
        .INSTR_WIDTH(32),
        .C_SIG_WIDTH(7),
        .ALU_SIG_WIDTH(3),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pc_in(pc_in),
        .instr_in(instr_in),
        .c_sig_in(c_sig_in),
        .alu_sig_in(alu_sig_in),
        .imm_in(imm_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pc_out(pc_out),
        .instr_out(instr_out),
        .c_sig_out(c_sig_out),
        .alu_sig_out(alu_sig_out),
        .imm_out(imm_out),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Companion fields are fixed functions of the PC so every field is checkable.
    function automatic logic [31:0] f_instr(input logic [11:0] pc);
        return {20'hABCDE, pc};
    endfunction
    function automatic logic [6:0] f_csig(input logic [11:0] pc);
        return pc[8:2];
    endfunction
    function automatic logic [2:0] f_alu(input logic [11:0] pc);
        return pc[4:2];
    endfunction
    function automatic logic [31:0] f_imm(input logic [11:0] pc);
        return {20'hFFFF0, pc} ^ 32'h0000_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_head(input string tag, input logic [11:0] pc);
        check({tag, ".pc"},    32'(pc_out),      32'(pc));
        check({tag, ".instr"}, instr_out,        f_instr(pc));
        check({tag, ".csig"},  32'(c_sig_out),   32'(f_csig(pc)));
        check({tag, ".alu"},   32'(alu_sig_out), 32'(f_alu(pc)));
        check({tag, ".imm"},   imm_out,          f_imm(pc));
    endtask

    task automatic drive(input logic v, input logic [11:0] pc);
        in_valid   = v;
        pc_in      = pc;
        instr_in   = f_instr(pc);
        c_sig_in   = f_csig(pc);
        alu_sig_in = f_alu(pc);
        imm_in     = f_imm(pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp_pc;
        n_pass  = 0;
        n_total = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 12'h000);

        // Reset then idle
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst.count",     32'(count),     32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.pc_out",    32'(pc_out),    32'd0);
        check("rst.imm_out",   imm_out,        32'd0);
        tick();

        // Fill, one-cycle latency on the first bundle
        drive(1'b1, 12'h004);
        tick();
        check("lat.count",     32'(count),     32'd1);
        check("lat.out_valid", 32'(out_valid), 32'd1);
        check_head("lat", 12'h004);
        drive(1'b1, 12'h008);
        tick();
        drive(1'b1, 12'h00C);
        tick();
        drive(1'b1, 12'h010);
        tick();
        check("fill.count",    32'(count),    32'd4);
        check("fill.in_ready", 32'(in_ready), 32'd0);
        check("fill.pc_out",   32'(pc_out),   32'h004);
        drive(1'b1, 12'h014);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fill.hold_count", 32'(count), 32'd4);
        end
        drive(1'b0, 12'h000);

        // Drain in order
        out_ready = 1'b1;
        exp_pc = 12'h004;
        for (int i = 0; i < 4; i++) begin
            check_head("drain", exp_pc);
            tick();
            exp_pc = exp_pc + 12'h004;
        end
        check("drain.out_valid", 32'(out_valid), 32'd0);
        check("drain.count",     32'(count),     32'd0);
        check("drain.pc_zero",   32'(pc_out),    32'd0);
        check("drain.in_ready",  32'(in_ready),  32'd1);

        // Sustained push+pop at count = 2 with pointer wrap
        out_ready = 1'b0;
        drive(1'b1, 12'h020);
        tick();
        drive(1'b1, 12'h024);
        tick();
        check("pp.count0", 32'(count), 32'd2);
        out_ready = 1'b1;
        exp_pc = 12'h020;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 12'h028 + 12'(4 * i));
            check_head("pp", exp_pc);
            tick();
            check("pp.count", 32'(count), 32'd2);
            exp_pc = exp_pc + 12'h004;
        end
        check_head("pp.end", 12'h038);
        drive(1'b0, 12'h000);
        out_ready = 1'b0;

        // Full with both sides active: pop only, then accept
        drive(1'b1, 12'h040);
        tick();
        drive(1'b1, 12'h044);
        tick();
        check("full.count", 32'(count), 32'd4);
        drive(1'b1, 12'h048);
        out_ready = 1'b1;
        check("full.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("full.pop_count", 32'(count), 32'd3);
        check("full.head",      32'(pc_out), 32'h03C);
        out_ready = 1'b0;
        tick();
        check("full.acc_count", 32'(count), 32'd4);
        drive(1'b0, 12'h000);
        out_ready = 1'b1;
        tick();
        check("full.after_count", 32'(count), 32'd3);
        check_head("full.after", 12'h040);

        // Flush beats a simultaneous push and pop
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 12'h050);
        tick();
        flush = 1'b0;
        drive(1'b0, 12'h000);
        check("flush.count",     32'(count),     32'd0);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.in_ready",  32'(in_ready),  32'd1);
        tick();
        check("flush.still0", 32'(count), 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 12'h060);
        tick();
        drive(1'b1, 12'h064);
        tick();
        drive(1'b0, 12'h000);
        check("postflush.count", 32'(count), 32'd2);
        check_head("postflush", 12'h060);

        // Asynchronous reset mid-drain
        out_ready = 1'b1;
        tick();
        check("mid.count", 32'(count), 32'd1);
        check("mid.head",  32'(pc_out), 32'h064);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.count",     32'(count),     32'd0);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready",  32'(in_ready),  32'd1);
        check("arst.pc_out",    32'(pc_out),    32'd0);
        check("arst.imm_out",   imm_out,        32'd0);
        tick();
        check("arst.held", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
